axi_stream_master: RTL and testbench
====================================

AXI_STREAM_MASTER -- requirements
Module: axi_stream_master

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port data_in, input, 32 bits: sample word to transmit.
REQ-004 SHALL have port send_packet, input, 1 bit: request to send data_in as a data packet.
REQ-005 SHALL have port send_mean, input, 1 bit: request to send a mean packet.
REQ-006 SHALL have port axi, interface axi_if.master: AXI-Stream source side.
REQ-007 SHALL provide interface axi_if with four signals: tdata (8 bits, data byte), tvalid (1 bit, beat valid), tlast (1 bit, final beat), tready_in (1 bit, sink ready); modport master drives tdata/tvalid/tlast and reads tready_in; modport slave is the mirror.

Function
REQ-008 SHALL implement states IDLE and SEND, plus a 3-bit beat index 0..4.
REQ-009 SHALL accept a request only in IDLE, sampled at a rising edge; tvalid asserts on the following cycle (1-cycle latency).
REQ-010 SHALL give send_packet priority over send_mean when both are high in the same IDLE cycle; the mean request is dropped.
REQ-011 SHALL ignore both requests while in SEND (no queuing).
REQ-012 SHALL send every packet as 5 byte beats: header, then 32-bit payload MSB byte first.
REQ-013 SHALL use header 0x01 with payload = data_in captured at acceptance for a data packet.
REQ-014 SHALL use header 0x02 with payload = mean for a mean packet, the payload frozen at acceptance.
REQ-015 SHALL keep a 4-entry sample history, shifted with data_in on every accepted send_packet.
REQ-016 SHALL compute mean = (sum of the 4 history entries, 34-bit, no overflow) >> 2, truncating; entries never written count as 0.
REQ-017 SHALL complete a beat only when tvalid and tready_in are both high at a rising edge.
REQ-018 SHALL hold tdata, tvalid and tlast stable while tvalid=1 and tready_in=0.
REQ-019 SHALL assert tlast only on beat 4, together with tvalid.
REQ-020 SHALL return to IDLE after the beat-4 handshake; tvalid is low for at least one cycle between packets.
REQ-021 SHALL transfer one beat per cycle when tready_in is continuously high (5 cycles per packet).
REQ-022 SHALL drive tdata to 0x00 whenever tvalid=0.

Reset
REQ-023 SHALL, while rst_n=0, force state IDLE, beat index 0, tvalid=0, tlast=0, tdata=0x00, and clear the history and captured payload to 0.
REQ-024 SHALL abort any packet in progress on reset mid-packet, with no further beats after release.
REQ-025 SHALL accept a request on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL, when AXIS_MEAN_EN is defined, include the history, mean logic and send_mean handling as specified above.
REQ-027 SHALL, when AXIS_MEAN_EN is undefined, ignore send_mean, omit the history/mean logic, and emit only header-0x01 packets.

Verification
REQ-028 SHALL verify: reset released, tready_in=1, send_packet pulse with data_in=0xAABBCCDD -> next cycle beats 01,AA,BB,CC,DD on 5 consecutive cycles, tlast only on DD.
REQ-029 SHALL verify: data packet 0x12341234 with random tready_in (70% high) -> the same 5 bytes in order, tdata/tvalid stable during every stall, exactly one tlast.
REQ-030 SHALL verify: data packets 0x10, 0x20, 0x30, 0x40, then send_mean (AXIS_MEAN_EN defined) -> beats 02,00,00,00,28.
REQ-031 SHALL verify: send_packet 0x55AA55AA pulsed again two cycles into a packet -> ignored, only the original packet is sent; simultaneous send_packet+send_mean in IDLE -> only the 0x01 packet is sent.
REQ-032 SHALL verify: rst_n low after beat 2 of a packet -> tvalid=0 immediately, and after release a new request yields a full packet starting at 0x01.
REQ-033 SHALL verify: AXIS_MEAN_EN undefined, send_mean pulsed -> tvalid stays 0.

Source files
------------

// File: rtl/axi_stream_master_if.sv
// AXI-Stream byte channel between a packet source and its sink.
// The master modport drives the beat; the slave modport returns ready.
interface axi_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready_in;

  modport master (output tdata, output tvalid, output tlast, input tready_in);
  modport slave  (input tdata, input tvalid, input tlast, output tready_in);
endinterface

// File: rtl/axi_stream_master.sv
// AXI-Stream packet source: sends 5-byte packets (header + 32-bit payload,
// MSB byte first). A data packet carries the sampled word; a mean packet
// carries the truncated average of the last four sampled words.
// Optional feature macro: AXIS_MEAN_EN (history, mean and send_mean handling).
module axi_stream_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        send_packet,
  input  logic        send_mean,
  axi_if.master       axi
);

  localparam int          DATA_W    = 32;
  localparam logic [7:0]  HDR_DATA  = 8'h01;
  localparam logic [2:0]  LAST_BEAT = 3'd4;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state, state_next;
  logic [2:0]          beat, beat_next;
  logic [7:0]          header;
  logic [DATA_W-1:0]   payload;
  logic                accept_data;
  logic                accept_mean;
  logic [7:0]          tdata;
  logic                tvalid;
  logic                tlast;

  // Requests are only taken while idle; a data request wins over a mean one.
  assign accept_data = (state == IDLE) && send_packet;

`ifdef AXIS_MEAN_EN
  localparam logic [7:0] HDR_MEAN = 8'h02;

  logic [3:0][DATA_W-1:0] hist;

  // Sum is widened by two bits so four full-scale words cannot overflow.
  function automatic logic [DATA_W-1:0] mean4(input logic [3:0][DATA_W-1:0] h);
    logic [DATA_W+1:0] sum;
    sum = {2'b00, h[0]} + {2'b00, h[1]} + {2'b00, h[2]} + {2'b00, h[3]};
    return sum[DATA_W+1:2];
  endfunction

  assign accept_mean = (state == IDLE) && !send_packet && send_mean;

  // Sample history: newest word enters at index 0 on every accepted data packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (accept_data) begin
      hist <= {hist[2:0], data_in};
    end
  end
`else
  logic unused_send_mean;
  assign unused_send_mean = send_mean;
  assign accept_mean      = 1'b0;
`endif

  // Capture header and payload at acceptance so they stay frozen for the packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      header  <= '0;
      payload <= '0;
    end else if (accept_data) begin
      header  <= HDR_DATA;
      payload <= data_in;
`ifdef AXIS_MEAN_EN
    end else if (accept_mean) begin
      header  <= HDR_MEAN;
      payload <= mean4(hist);
`endif
    end
  end

  // State and beat index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  // Next state: advance one beat per handshake, back to idle after the last.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    case (state)
      IDLE: begin
        if (accept_data || accept_mean) begin
          state_next = SEND;
          beat_next  = '0;
        end
      end
      SEND: begin
        if (axi.tready_in) begin
          if (beat == LAST_BEAT) begin
            state_next = IDLE;
            beat_next  = '0;
          end else begin
            beat_next = beat + 3'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = '0;
      end
    endcase
  end

  // Beat outputs decode purely from registers, so they hold through stalls.
  always_comb begin
    tvalid = (state == SEND);
    tlast  = tvalid && (beat == LAST_BEAT);
    tdata  = 8'h00;
    if (tvalid) begin
      case (beat)
        3'd0:    tdata = header;
        3'd1:    tdata = payload[31:24];
        3'd2:    tdata = payload[23:16];
        3'd3:    tdata = payload[15:8];
        3'd4:    tdata = payload[7:0];
        default: tdata = 8'h00;
      endcase
    end
  end

  assign axi.tdata  = tdata;
  assign axi.tvalid = tvalid;
  assign axi.tlast  = tlast;

endmodule

// File: tb/tb_axi_stream_master.sv
// Directed testbench for axi_stream_master. Inputs change and outputs are
// sampled on the falling clock edge. Build with +define+AXIS_MEAN_EN to
// exercise the mean packet; without it the bench checks send_mean is ignored.
module tb_axi_stream_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        send_packet;
  logic        send_mean;
  int          n_checks = 0;
  int          n_fail   = 0;

  axi_if bus ();

  axi_stream_master dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .send_packet (send_packet),
    .send_mean   (send_mean),
    .axi         (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse a request for one cycle, starting at a falling edge.
  task automatic request(input logic [31:0] d, input logic p, input logic m);
    data_in     = d;
    send_packet = p;
    send_mean   = m;
    @(negedge clk);
    send_packet = 1'b0;
    send_mean   = 1'b0;
  endtask

  // Collect one packet's handshaken bytes; counts protocol slips, no verdicts.
  task automatic collect(input bit rnd, output logic [39:0] bytes, output int nbeats,
                         output int nlast, output int proto_err, output int lat,
                         output int cycles);
    bit         done;
    logic       prev_stall;
    logic [7:0] prev_data;
    bytes = '0; nbeats = 0; nlast = 0; proto_err = 0; lat = 0; cycles = 0;
    done = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
    while (bus.tvalid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    while (!done && cycles < 400 && lat < 50) begin
      bus.tready_in = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      if (prev_stall && (bus.tvalid !== 1'b1 || bus.tdata !== prev_data)) proto_err++;
      if (bus.tvalid !== 1'b1 && (bus.tdata !== 8'h00 || bus.tlast !== 1'b0)) proto_err++;
      if (bus.tvalid === 1'b1 && bus.tready_in === 1'b1) begin
        bytes = {bytes[31:0], bus.tdata};
        nbeats++;
        if (bus.tlast === 1'b1) begin
          nlast++;
          done = 1'b1;
        end
      end
      prev_stall = (bus.tvalid === 1'b1) && (bus.tready_in === 1'b0);
      prev_data  = bus.tdata;
      cycles++;
      @(negedge clk);
    end
    bus.tready_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_in = '0; send_packet = 1'b0; send_mean = 1'b0;
    bus.tready_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", bus.tvalid); end
    n_checks++;
    if (bus.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", bus.tlast); end
    n_checks++;
    if (bus.tdata !== 8'h00) begin n_fail++; $display("FAIL reset_tdata: got %h want 00", bus.tdata); end
  endtask

  // Release reset and request on the very next rising edge.
  task automatic test_basic();
    logic [39:0] b; int nb, nl, pe, lat, cyc;
    rst_n = 1'b1;
    request(32'hAABBCCDD, 1'b1, 1'b0);
    collect(1'b0, b, nb, nl, pe, lat, cyc);
    n_checks++;
    if (lat != 0) begin n_fail++; $display("FAIL basic_latency: got %0d want 0", lat); end
    n_checks++;
    if (b !== 40'h01AABBCCDD) begin n_fail++; $display("FAIL basic_bytes: got %h want 01aabbccdd", b); end
    n_checks++;
    if (nb != 5 || cyc != 5) begin n_fail++; $display("FAIL basic_beats: got %0d beats in %0d cycles want 5 in 5", nb, cyc); end
    n_checks++;
    if (nl != 1 || pe != 0) begin n_fail++; $display("FAIL basic_tlast: got tlast=%0d proto=%0d want 1 and 0", nl, pe); end
    n_checks++;
    if (bus.tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_gap: got tvalid %b want 0", bus.tvalid); end
  endtask

  task automatic test_stall();
    logic [39:0] b; int nb, nl, pe, lat, cyc;
    request(32'h12341234, 1'b1, 1'b0);
    collect(1'b1, b, nb, nl, pe, lat, cyc);
    n_checks++;
    if (b !== 40'h0112341234 || nb != 5) begin n_fail++; $display("FAIL stall_bytes: got %h (%0d beats) want 0112341234 (5)", b, nb); end
    n_checks++;
    if (nl != 1) begin n_fail++; $display("FAIL stall_tlast: got %0d want 1", nl); end
    n_checks++;
    if (pe != 0) begin n_fail++; $display("FAIL stall_stable: got %0d slips want 0", pe); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp [5];
    logic [39:0] b; int nb, nl, pe, lat, cyc;
    int          extra;
    exp[0] = 8'h01; exp[1] = 8'h11; exp[2] = 8'h22; exp[3] = 8'h33; exp[4] = 8'h44;
    bus.tready_in = 1'b1;
    request(32'h11223344, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.tvalid !== 1'b1 || bus.tdata !== exp[i] || bus.tlast !== (i == 4)) begin
        n_fail++;
        $display("FAIL ignore_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, bus.tvalid, bus.tdata, bus.tlast, exp[i], (i == 4));
      end
      if (i == 2) begin data_in = 32'h55AA55AA; send_packet = 1'b1; end
      if (i == 3) send_packet = 1'b0;
      @(negedge clk);
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.tvalid !== 1'b0) extra++;
      @(negedge clk);
    end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL ignore_requeue: got %0d valid cycles want 0", extra); end
    request(32'hDEADBEEF, 1'b1, 1'b1);
    collect(1'b0, b, nb, nl, pe, lat, cyc);
    n_checks++;
    if (b !== 40'h01DEADBEEF || nb != 5) begin n_fail++; $display("FAIL priority_bytes: got %h want 01deadbeef", b); end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.tvalid !== 1'b0) extra++;
      @(negedge clk);
    end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL priority_drop: got %0d valid cycles want 0", extra); end
  endtask

`ifdef AXIS_MEAN_EN
  task automatic test_mean();
    logic [39:0] b; int nb, nl, pe, lat, cyc;
    for (int i = 1; i <= 4; i++) begin
      request(32'(i * 16), 1'b1, 1'b0);
      collect(1'b0, b, nb, nl, pe, lat, cyc);
    end
    request(32'h0, 1'b0, 1'b1);
    collect(1'b0, b, nb, nl, pe, lat, cyc);
    n_checks++;
    if (b !== 40'h0200000028 || nb != 5) begin n_fail++; $display("FAIL mean_bytes: got %h want 0200000028", b); end
    n_checks++;
    if (nl != 1 || lat != 0) begin n_fail++; $display("FAIL mean_frame: got tlast=%0d lat=%0d want 1 and 0", nl, lat); end
  endtask
`else
  task automatic test_mean();
    int seen;
    request(32'h0000FFFF, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.tvalid !== 1'b0) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL mean_disabled: got %0d valid cycles want 0", seen); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [39:0] b; int nb, nl, pe, lat, cyc;
    int          seen;
    bus.tready_in = 1'b1;
    request(32'hCAFEBABE, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.tdata !== 8'hBA) begin n_fail++; $display("FAIL midrst_pre: got %h want ba", bus.tdata); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.tvalid !== 1'b0 || bus.tdata !== 8'h00 || bus.tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_abort: got v=%b d=%h l=%b want 0 00 0", bus.tvalid, bus.tdata, bus.tlast);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.tvalid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL midrst_resume: got %0d valid cycles want 0", seen); end
    request(32'h0F0E0D0C, 1'b1, 1'b0);
    collect(1'b0, b, nb, nl, pe, lat, cyc);
    n_checks++;
    if (b !== 40'h010F0E0D0C || nb != 5 || nl != 1) begin
      n_fail++;
      $display("FAIL midrst_packet: got %h (%0d beats, %0d tlast) want 010f0e0d0c (5, 1)", b, nb, nl);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_mean();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
